// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Selects EX operand bypass sources and stalls/bubbles the front end around load results.
module fwd_hazard_unit #(
    parameter int AW       = 4,
    parameter int NUM_SRC  = 2,
    parameter int SP_REG   = 10,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [NUM_SRC*AW-1:0] id_src,
    input  logic                  id_mem_access,
    input  logic [NUM_SRC*AW-1:0] ex_src,
    input  logic                  ex_mem_access,
    input  logic [AW-1:0]         ex_dst,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [AW-1:0]         mem_dst,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic [AW-1:0]         wb_dst,
    input  logic                  wb_reg_write,
    output logic [NUM_SRC*2-1:0]  fwd_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_cycles
);

    localparam logic [AW-1:0] SP_ADDR   = AW'(SP_REG);
    localparam logic [3:0]    HOLD_INIT = 4'(LOAD_LAT - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [3:0] hold_cnt;
    logic       load_use;

    // Operand 0 of a memory op implicitly reads the stack register as its base.
    function automatic logic src_match(input logic [AW-1:0] src, input logic is_op0,
                                       input logic mem_acc, input logic [AW-1:0] dst);
        return (dst != '0) && ((src == dst) || (is_op0 && mem_acc && (dst == SP_ADDR)));
    endfunction

    always_comb begin
        fwd_sel = {NUM_SRC{2'd2}};
        if (rest) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (mem_reg_write && !mem_mem_read &&
                    src_match(ex_src[k*AW +: AW], k == 0, ex_mem_access, mem_dst))
                    fwd_sel[k*2 +: 2] = 2'd0;
                else if (wb_reg_write &&
                         src_match(ex_src[k*AW +: AW], k == 0, ex_mem_access, wb_dst))
                    fwd_sel[k*2 +: 2] = 2'd1;
            end
        end
    end

    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (src_match(id_src[k*AW +: AW], k == 0, id_mem_access, ex_dst))
                load_use = 1'b1;
        end
        load_use = load_use && id_valid && ex_reg_write && ex_mem_read;
    end

    // Flush and reset mask the stall in the same cycle; the FSM catches up on the next edge.
    assign stall  = rest && !flush && ((state == HOLD) || (state == IDLE && load_use));
    assign bubble = stall;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            stall_cycles <= '0;
        end else begin
            if (stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_use && (LOAD_LAT > 1)) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_INIT;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt <= 4'd1) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - 4'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: one LOAD_LAT=1 instance and one LOAD_LAT=3, CNT_W=4
// instance share the stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_fwd_hazard_unit;

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic       rest, flush, id_valid, id_mem_access, ex_mem_access;
    logic       ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, wb_reg_write;
    logic [7:0] id_src, ex_src;
    logic [3:0] ex_dst, mem_dst, wb_dst;

    logic [3:0]  fwd1, fwd3;
    logic        stall1, bubble1, stall3, bubble3;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    fwd_hazard_unit #(.AW(4), .NUM_SRC(2), .SP_REG(10), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rest(rest), .flush(flush), .id_valid(id_valid), .id_src(id_src),
        .id_mem_access(id_mem_access), .ex_src(ex_src), .ex_mem_access(ex_mem_access),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_dst(mem_dst), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .wb_dst(wb_dst), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd1), .stall(stall1), .bubble(bubble1), .stall_cycles(cnt1)
    );

    fwd_hazard_unit #(.AW(4), .NUM_SRC(2), .SP_REG(10), .LOAD_LAT(3), .CNT_W(4)) u_lat3 (
        .clk(clk), .rest(rest), .flush(flush), .id_valid(id_valid), .id_src(id_src),
        .id_mem_access(id_mem_access), .ex_src(ex_src), .ex_mem_access(ex_mem_access),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_dst(mem_dst), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .wb_dst(wb_dst), .wb_reg_write(wb_reg_write),
        .fwd_sel(fwd3), .stall(stall3), .bubble(bubble3), .stall_cycles(cnt3)
    );

    typedef struct packed {
        logic [3:0]  fwd;
        logic        s1;
        logic [15:0] c1;
        logic        s3;
        logic [3:0]  c3;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check_output(input string name, input string field,
                                input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s.%s got=%0h want=%0h", name, field, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check_output(n, "fwd1",    {12'd0, fwd1},    {12'd0, e.fwd});
            check_output(n, "fwd3",    {12'd0, fwd3},    {12'd0, e.fwd});
            check_output(n, "stall1",  {15'd0, stall1},  {15'd0, e.s1});
            check_output(n, "bubble1", {15'd0, bubble1}, {15'd0, e.s1});
            check_output(n, "cnt1",    cnt1,             e.c1);
            check_output(n, "stall3",  {15'd0, stall3},  {15'd0, e.s3});
            check_output(n, "bubble3", {15'd0, bubble3}, {15'd0, e.s3});
            check_output(n, "cnt3",    {12'd0, cnt3},    {12'd0, e.c3});
        end
    end

    // Inputs are already applied; queue this cycle's expectation and advance one cycle.
    task automatic apply_stimulus(input string name, input logic [3:0] fwd, input logic s1,
                                  input int c1, input logic s3, input int c3);
        exp_t e;
        e.fwd = fwd;
        e.s1  = s1;
        e.c1  = 16'(c1);
        e.s3  = s3;
        e.c3  = 4'(c3);
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rest = 1'b1; flush = 1'b0; id_valid = 1'b0; id_mem_access = 1'b0; ex_mem_access = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b0; mem_mem_read = 1'b0;
        wb_reg_write = 1'b0; id_src = 8'h00; ex_src = 8'h00;
        ex_dst = 4'd0; mem_dst = 4'd0; wb_dst = 4'd0;
    endtask

    task automatic set_load_use();
        set_idle();
        id_valid = 1'b1; id_src = {4'd4, 4'd0};
        ex_dst = 4'd4; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
    endtask

    initial begin
        set_load_use();
        rest = 1'b0;
        ex_src = {4'd0, 4'd3}; mem_dst = 4'd3; mem_reg_write = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus("reset", 4'b1010, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_src = {4'd0, 4'd3}; mem_dst = 4'd3; mem_reg_write = 1'b1;
        wb_dst = 4'd3; wb_reg_write = 1'b1;
        apply_stimulus("exmem_prio", 4'b1000, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_src = {4'd0, 4'd3}; wb_dst = 4'd3; wb_reg_write = 1'b1;
        apply_stimulus("memwb_op0", 4'b1001, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_mem_access = 1'b1; ex_src = {4'd0, 4'd5}; wb_dst = 4'd10; wb_reg_write = 1'b1;
        apply_stimulus("implicit_sp", 4'b1001, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_mem_access = 1'b1; wb_reg_write = 1'b1; mem_reg_write = 1'b1;
        apply_stimulus("reg0_never", 4'b1010, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_src = {4'd6, 4'd0}; mem_dst = 4'd6; mem_reg_write = 1'b1; mem_mem_read = 1'b1;
        apply_stimulus("no_load_bypass", 4'b1010, 1'b0, 0, 1'b0, 0);

        wb_dst = 4'd6; wb_reg_write = 1'b1;
        apply_stimulus("load_via_wb", 4'b0110, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_src = {4'd6, 4'd7}; mem_dst = 4'd6; mem_reg_write = 1'b1;
        wb_dst = 4'd7; wb_reg_write = 1'b1;
        apply_stimulus("split_ops", 4'b0001, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_src = {4'd10, 4'd9}; mem_dst = 4'd10; mem_reg_write = 1'b1;
        apply_stimulus("no_sp_wo_mem", 4'b0010, 1'b0, 0, 1'b0, 0);

        set_idle(); ex_src = {4'd0, 4'd3}; mem_dst = 4'd3; wb_dst = 4'd3;
        apply_stimulus("no_write_en", 4'b1010, 1'b0, 0, 1'b0, 0);

        set_load_use();
        apply_stimulus("lu_detect", 4'b1010, 1'b1, 0, 1'b1, 0);
        set_idle();
        apply_stimulus("lu_hold1", 4'b1010, 1'b0, 1, 1'b1, 1);
        apply_stimulus("lu_hold2", 4'b1010, 1'b0, 1, 1'b1, 2);
        apply_stimulus("lu_release", 4'b1010, 1'b0, 1, 1'b0, 3);

        set_idle(); id_valid = 1'b1; id_mem_access = 1'b1; id_src = {4'd0, 4'd2};
        ex_dst = 4'd10; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        apply_stimulus("lu_sp", 4'b1010, 1'b1, 1, 1'b1, 3);
        set_idle(); flush = 1'b1;
        apply_stimulus("flush_hold", 4'b1010, 1'b0, 2, 1'b0, 4);
        set_idle();
        apply_stimulus("after_flush", 4'b1010, 1'b0, 2, 1'b0, 4);

        set_load_use(); flush = 1'b1;
        apply_stimulus("flush_detect", 4'b1010, 1'b0, 2, 1'b0, 4);
        set_idle();
        apply_stimulus("no_hold_entry", 4'b1010, 1'b0, 2, 1'b0, 4);

        set_load_use(); id_valid = 1'b0;
        apply_stimulus("id_invalid", 4'b1010, 1'b0, 2, 1'b0, 4);
        set_load_use(); id_src = 8'h00; ex_dst = 4'd0;
        apply_stimulus("lu_reg0", 4'b1010, 1'b0, 2, 1'b0, 4);

        for (int i = 0; i < 20; i++) begin
            set_load_use();
            apply_stimulus("saturate", 4'b1010, 1'b1, 2 + i, 1'b1, (4 + i > 15) ? 15 : 4 + i);
        end

        set_load_use(); rest = 1'b0; ex_src = {4'd0, 4'd3}; mem_dst = 4'd3; mem_reg_write = 1'b1;
        apply_stimulus("reset_mid_hold", 4'b1010, 1'b0, 0, 1'b0, 0);
        set_idle();
        apply_stimulus("post_reset", 4'b1010, 1'b0, 0, 1'b0, 0);
        set_load_use();
        apply_stimulus("relaunch", 4'b1010, 1'b1, 0, 1'b1, 0);
        set_idle();
        apply_stimulus("relaunch_hold", 4'b1010, 1'b0, 1, 1'b1, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
